display_timing_controller: RTL and testbench

Generates the 640x480@60 raster that sequences the background generator and every later pixel stage. It advances horizontal/vertical counters on `pixel_clk`, drives `pixel_x`, `pixel_y`, `display_enable`, `hsync`, `vsync` and a `frame_start` pulse, and owns the background colour register. A valid/ready configuration port updates that register. Updates are committed only at frame boundaries, so a frame never shows mixed colours.

---
 rtl/display_pkg.sv | 37 +++
 rtl/raster_axis_counter.sv | 65 ++++++
 rtl/display_timing_controller.sv | 156 +++++++++++++++
 tb/tb_display_timing_controller.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared 640x480@60 raster timing constants, derived line and
//                frame totals, colour type and reference colours for the
//                display pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
package display_pkg;

    // Horizontal timing in pixels
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    // Vertical timing in lines
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Coordinate counters are 10 bits; any axis total must fit in that range.
    localparam int CNT_W        = 10;
    localparam int MAX_TOTAL    = 1 << CNT_W;

    typedef logic [CNT_W-1:0] coord_t;
    typedef logic [7:0]       color332_t;   // RRRGGGBB

    localparam color332_t COLOR_BLACK      = 8'h00;
    localparam color332_t BACKGROUND_COLOR = 8'b00100101;

endpackage
`default_nettype wire

// File: rtl/raster_axis_counter.sv
`default_nettype none
// ============================================================================
//  Module      : raster_axis_counter
//  Description : One raster axis (horizontal or vertical). Counts 0..TOTAL-1
//                while step is high and decodes active / sync regions.
//  Ports       : clk, rst_n   - clock, async active-low reset
//                step         - advance the counter this cycle
//                count        - current (registered) position
//                wrap         - count is at TOTAL-1 (next step returns to 0)
//                active       - position after this edge is < ACTIVE
//                in_sync      - position after this edge is in the sync band
//  Revision    : 1.0  initial release
// ============================================================================
module raster_axis_counter
    import display_pkg::*;
#(
    parameter int TOTAL      = 800,
    parameter int SYNC_START = 656,
    parameter int SYNC_LEN   = 96,
    parameter int ACTIVE     = 640
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   step,
    output coord_t count,
    output logic   wrap,
    output logic   active,
    output logic   in_sync
);

    localparam coord_t C_LAST       = coord_t'(TOTAL - 1);
    localparam coord_t C_ACTIVE     = coord_t'(ACTIVE);
    localparam coord_t C_SYNC_FIRST = coord_t'(SYNC_START);
    localparam coord_t C_SYNC_LAST  = coord_t'(SYNC_START + SYNC_LEN - 1);

    coord_t r_count;
    coord_t w_next;

    assign wrap = (r_count == C_LAST);

    always_comb begin
        w_next = r_count;
        if (step) begin
            w_next = wrap ? '0 : r_count + coord_t'(1);
        end
    end

    // active / in_sync describe the value the counter is about to take, so a
    // parent that registers them lines its flops up with count.
    assign active  = (w_next < C_ACTIVE);
    assign in_sync = (w_next >= C_SYNC_FIRST) && (w_next <= C_SYNC_LAST);

    // Reset parks on the last position so the first edge lands on 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= C_LAST;
        end else begin
            r_count <= w_next;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/display_timing_controller.sv
`default_nettype none
// ============================================================================
//  Module      : display_timing_controller
//  Description : Raster timing generator (default 640x480@60) plus the
//                background colour register. New colours arrive on a
//                valid/ready port, wait in a single pending slot and are
//                committed only on the frame-wrap edge, so every frame shows
//                one colour.
//  Ports       : pixel_clk, reset_n       - clock, async active-low reset
//                cfg_valid/cfg_color      - colour offer (RRRGGGBB)
//                cfg_ready                - pending slot empty
//                pixel_x, pixel_y         - raster position
//                display_enable           - inside the visible area
//                hsync, vsync             - syncs at SYNC_ACTIVE polarity
//                frame_start              - one-cycle pulse at (0,0)
//                bg_color_332             - committed background colour
//  Revision    : 1.0  initial release
// ============================================================================
module display_timing_controller
    import display_pkg::*;
#(
    parameter int   H_ACTIVE    = VGA_H_ACTIVE,
    parameter int   H_FP        = VGA_H_FP,
    parameter int   H_SYNC      = VGA_H_SYNC,
    parameter int   H_BP        = VGA_H_BP,
    parameter int   V_ACTIVE    = VGA_V_ACTIVE,
    parameter int   V_FP        = VGA_V_FP,
    parameter int   V_SYNC      = VGA_V_SYNC,
    parameter int   V_BP        = VGA_V_BP,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic      pixel_clk,
    input  logic      reset_n,
    input  logic      cfg_valid,
    input  color332_t cfg_color,
    output logic      cfg_ready,
    output coord_t    pixel_x,
    output coord_t    pixel_y,
    output logic      display_enable,
    output logic      hsync,
    output logic      vsync,
    output logic      frame_start,
    output color332_t bg_color_332
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_check
            $error("display_timing_controller: H_TOTAL/V_TOTAL exceed counter range");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Axis counters
    // ------------------------------------------------------------------
    coord_t w_h_count;
    coord_t w_v_count;
    logic   w_h_wrap;
    logic   w_v_wrap;
    logic   w_h_active;
    logic   w_v_active;
    logic   w_h_sync;
    logic   w_v_sync;
    logic   w_frame_wrap;

    raster_axis_counter #(
        .TOTAL      (H_TOTAL),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_LEN   (H_SYNC),
        .ACTIVE     (H_ACTIVE)
    ) u_h_axis (
        .clk     (pixel_clk),
        .rst_n   (reset_n),
        .step    (1'b1),
        .count   (w_h_count),
        .wrap    (w_h_wrap),
        .active  (w_h_active),
        .in_sync (w_h_sync)
    );

    raster_axis_counter #(
        .TOTAL      (V_TOTAL),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_LEN   (V_SYNC),
        .ACTIVE     (V_ACTIVE)
    ) u_v_axis (
        .clk     (pixel_clk),
        .rst_n   (reset_n),
        .step    (w_h_wrap),
        .count   (w_v_count),
        .wrap    (w_v_wrap),
        .active  (w_v_active),
        .in_sync (w_v_sync)
    );

    // Both axes at their last position: this edge moves the raster to (0,0).
    assign w_frame_wrap = w_h_wrap && w_v_wrap;

    // ------------------------------------------------------------------
    // Registered raster outputs, decoded from the counters' next values
    // ------------------------------------------------------------------
    logic r_display_enable;
    logic r_hsync;
    logic r_vsync;
    logic r_frame_start;

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_display_enable <= 1'b0;
            r_hsync          <= ~SYNC_ACTIVE;
            r_vsync          <= ~SYNC_ACTIVE;
            r_frame_start    <= 1'b0;
        end else begin
            r_display_enable <= w_h_active && w_v_active;
            r_hsync          <= w_h_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vsync          <= w_v_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_frame_start    <= w_frame_wrap;
        end
    end

    // ------------------------------------------------------------------
    // Background colour: one pending slot, committed on the frame wrap
    // ------------------------------------------------------------------
    color332_t r_pending_color;
    logic      r_pending;
    color332_t r_bg_color;

    // With the slot full no accept can happen, and with it empty the commit
    // is a no-op, so the two branches never compete on the same edge.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending_color <= COLOR_BLACK;
            r_pending       <= 1'b0;
            r_bg_color      <= BACKGROUND_COLOR;
        end else if (w_frame_wrap && r_pending) begin
            r_bg_color <= r_pending_color;
            r_pending  <= 1'b0;
        end else if (cfg_valid && !r_pending) begin
            r_pending_color <= cfg_color;
            r_pending       <= 1'b1;
        end
    end

    assign cfg_ready      = ~r_pending;
    assign pixel_x        = w_h_count;
    assign pixel_y        = w_v_count;
    assign display_enable = r_display_enable;
    assign hsync          = r_hsync;
    assign vsync          = r_vsync;
    assign frame_start    = r_frame_start;
    assign bg_color_332   = r_bg_color;

endmodule
`default_nettype wire

// File: tb/tb_display_timing_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_timing_controller
//  Description : Self-checking bench. A full-size 640x480 instance covers
//                reset and line-0 timing; a scaled 80x58 instance covers
//                whole-frame timing, colour commit and mid-frame reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_display_timing_controller;

    // Scaled raster: H 64/4/8/4 = 80, V 48/3/2/5 = 58
    localparam int SH_T = 80;
    localparam int SV_T = 58;
    localparam int FR   = SH_T * SV_T;
    localparam int RST_CYC = 2 * FR + 20 * SH_T + 30;   // position (30,20)

    logic       clk;
    logic       reset_n;
    logic       cfg_valid;
    logic [7:0] cfg_color;
    logic       d_cfg_valid;
    logic [7:0] d_cfg_color;

    logic       s_rdy, s_de, s_hs, s_vs, s_fs;
    logic [9:0] s_x, s_y;
    logic [7:0] s_bg;
    logic       d_rdy, d_de, d_hs, d_vs, d_fs;
    logic [9:0] d_x, d_y;
    logic [7:0] d_bg;

    int n_vec  = 0;
    int n_miss = 0;
    int hs_low = 0;
    int de_hi  = 0;

    display_timing_controller u_dut_full (
        .pixel_clk      (clk),
        .reset_n        (reset_n),
        .cfg_valid      (d_cfg_valid),
        .cfg_color      (d_cfg_color),
        .cfg_ready      (d_rdy),
        .pixel_x        (d_x),
        .pixel_y        (d_y),
        .display_enable (d_de),
        .hsync          (d_hs),
        .vsync          (d_vs),
        .frame_start    (d_fs),
        .bg_color_332   (d_bg)
    );

    display_timing_controller #(
        .H_ACTIVE (64), .H_FP (4), .H_SYNC (8), .H_BP (4),
        .V_ACTIVE (48), .V_FP (3), .V_SYNC (2), .V_BP (5),
        .SYNC_ACTIVE (1'b0)
    ) u_dut_small (
        .pixel_clk      (clk),
        .reset_n        (reset_n),
        .cfg_valid      (cfg_valid),
        .cfg_color      (cfg_color),
        .cfg_ready      (s_rdy),
        .pixel_x        (s_x),
        .pixel_y        (s_y),
        .display_enable (s_de),
        .hsync          (s_hs),
        .vsync          (s_vs),
        .frame_start    (s_fs),
        .bg_color_332   (s_bg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation did not reach its end, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected scaled-raster outputs at cycle cyc after reset release.
    task automatic check_small(input int cyc);
        int         ex, ey;
        logic [23:0] expv;
        ex   = cyc % SH_T;
        ey   = (cyc / SH_T) % SV_T;
        expv = {10'(ex), 10'(ey), (ex < 64 && ey < 48), !(ex >= 68 && ex <= 75),
                !(ey >= 51 && ey <= 52), (ex == 0 && ey == 0)};
        chk($sformatf("s_raster@%0d", cyc), {8'h0, s_x, s_y, s_de, s_hs, s_vs, s_fs},
            {8'h0, expv});
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_s_raster"}, {8'h0, s_x, s_y, s_de, s_hs, s_vs, s_fs},
            {8'h0, 10'd79, 10'd57, 4'b0110});
        chk({tag, "_s_bg"},  32'(s_bg),  32'h25);
        chk({tag, "_s_rdy"}, 32'(s_rdy), 32'd1);
        chk({tag, "_d_raster"}, {8'h0, d_x, d_y, d_de, d_hs, d_vs, d_fs},
            {8'h0, 10'd799, 10'd524, 4'b0110});
        chk({tag, "_d_bg"},  32'(d_bg),  32'h25);
        chk({tag, "_d_rdy"}, 32'(d_rdy), 32'd1);
    endtask

    initial begin
        reset_n     = 1'b0;
        cfg_valid   = 1'b0;
        cfg_color   = 8'h00;
        d_cfg_valid = 1'b0;
        d_cfg_color = 8'h00;
        repeat (3) @(negedge clk);
        check_reset("rst_init");
        reset_n = 1'b1;

        // ---------------- phase A: timing and colour commit ----------------
        for (int cyc = 0; cyc <= RST_CYC; cyc++) begin
            @(negedge clk);
            check_small(cyc);

            // full-size line 0 and start of line 1
            if (cyc < 800) begin
                hs_low += (d_hs == 1'b0) ? 1 : 0;
                de_hi  += (d_de == 1'b1) ? 1 : 0;
            end
            case (cyc)
                0: begin
                    chk("d_first", {8'h0, d_x, d_y, d_de, d_hs, d_vs, d_fs},
                        {8'h0, 10'd0, 10'd0, 4'b1111});
                    chk("d_first_bg", 32'(d_bg), 32'h25);
                end
                639: chk("d_de@639", {21'h0, d_x, d_de}, {21'h0, 10'd639, 1'b1});
                640: chk("d_de@640", {21'h0, d_x, d_de}, {21'h0, 10'd640, 1'b0});
                655: chk("d_hs@655", 32'(d_hs), 32'd1);
                656: chk("d_hs@656", 32'(d_hs), 32'd0);
                751: chk("d_hs@751", 32'(d_hs), 32'd0);
                752: chk("d_hs@752", 32'(d_hs), 32'd1);
                799: chk("d_xy@799", {12'h0, d_x, d_y}, {12'h0, 10'd799, 10'd0});
                800: begin
                    chk("d_xy@800", {8'h0, d_x, d_y, d_fs, d_de, d_vs, 1'b0},
                        {8'h0, 10'd0, 10'd1, 4'b0110});
                    chk("d_hs_low_cnt", 32'(hs_low), 32'd96);
                    chk("d_de_hi_cnt",  32'(de_hi),  32'd640);
                end
                default: ;
            endcase

            // scaled colour path
            if (cyc == 0) begin
                chk("s_bg@0",  32'(s_bg),  32'h25);
                chk("s_rdy@0", 32'(s_rdy), 32'd1);
            end
            if (cyc == 1000) begin
                cfg_valid = 1'b1;
                cfg_color = 8'hE0;
            end
            if (cyc == 1001) begin
                chk("e0_accept_rdy", 32'(s_rdy), 32'd0);
                chk("e0_not_yet_bg", 32'(s_bg),  32'h25);
                cfg_valid = 1'b0;
                cfg_color = 8'hFF;
            end
            if (cyc == 2000) begin
                cfg_valid = 1'b1;
                cfg_color = 8'h1C;
            end
            if (cyc == 3000) chk("1c_stalled_rdy", 32'(s_rdy), 32'd0);
            if (cyc == FR - 1) begin
                chk("pre_commit_bg",  32'(s_bg),  32'h25);
                chk("pre_commit_rdy", 32'(s_rdy), 32'd0);
            end
            if (cyc == FR) begin
                chk("commit_e0_bg",  32'(s_bg),  32'hE0);
                chk("commit_e0_rdy", 32'(s_rdy), 32'd1);
            end
            if (cyc == FR + 1) begin
                chk("1c_accept_rdy", 32'(s_rdy), 32'd0);
                cfg_valid = 1'b0;
                cfg_color = 8'h00;
            end
            if (cyc == 2 * FR - 1) chk("e0_held_bg", 32'(s_bg), 32'hE0);
            if (cyc == 2 * FR) begin
                chk("commit_1c_bg",  32'(s_bg),  32'h1C);
                chk("commit_1c_rdy", 32'(s_rdy), 32'd1);
            end
            if (cyc == 2 * FR + 100) begin
                cfg_valid = 1'b1;
                cfg_color = 8'h03;
            end
            if (cyc == 2 * FR + 101) begin
                chk("03_accept_rdy", 32'(s_rdy), 32'd0);
                cfg_valid = 1'b0;
            end
            if (cyc == RST_CYC) begin
                chk("s_xy_before_rst", {12'h0, s_x, s_y}, {12'h0, 10'd30, 10'd20});
                #2 reset_n = 1'b0;
                #1 check_reset("rst_mid");
            end
        end

        // ---------------- phase B: recovery after mid-frame reset ----------
        repeat (2) @(negedge clk);
        check_reset("rst_hold");
        reset_n = 1'b1;
        for (int cyc = 0; cyc <= FR; cyc++) begin
            @(negedge clk);
            check_small(cyc);
            if (cyc == 0) begin
                chk("rel_s_bg",  32'(s_bg),  32'h25);
                chk("rel_s_rdy", 32'(s_rdy), 32'd1);
                chk("rel_d", {8'h0, d_x, d_y, d_de, d_hs, d_vs, d_fs},
                    {8'h0, 10'd0, 10'd0, 4'b1111});
            end
            if (cyc == FR) begin
                chk("no_stale_commit_bg", 32'(s_bg),  32'h25);
                chk("no_stale_rdy",       32'(s_rdy), 32'd1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
